// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending lines, fixed-priority pick (ID 1 highest),
// LOAD/REQ/SERVICE handshake with the core. Optional ack timeout under INT_ACK_TIMEOUT_EN.
module int_ctrl #(
    parameter int NUM_IRQ     = 31,
    parameter int ID_W        = 5,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               gie,
    input  logic               irq_ack,
    input  logic               irq_ret,
    output logic               irq_id_en,
    output logic [ID_W-1:0]    irq_id_D,
    output logic               irq_req,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_SERVICE} state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] hist_q, pend_q, pend_d;
    logic [NUM_IRQ-1:0] rise, cand, clr;
    logic [ID_W-1:0]    sel_id, id_q;
    logic               id_en_q, req_q, busy_q;

`ifdef INT_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    always_comb begin
        rise   = irq_lines & ~hist_q;
        cand   = pend_q & irq_mask;
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) sel_id = ID_W'(i + 1);
        end
        clr = '0;
        if (state_q == S_REQ && irq_ack) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (id_q == ID_W'(i + 1)) clr[i] = 1'b1;
            end
        end
        // a new edge on the bit being acknowledged wins over the clear
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            hist_q <= '0;
            pend_q <= '0;
        end else begin
            hist_q <= irq_lines;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            id_en_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef INT_ACK_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef INT_ACK_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (gie && (|cand)) begin
                        state_q <= S_LOAD;
                        id_q    <= sel_id;
                        id_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_REQ;
                    id_en_q <= 1'b0;
                    req_q   <= 1'b1;
`ifdef INT_ACK_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_REQ: begin
                    if (irq_ack) begin
                        state_q <= S_SERVICE;
                        req_q   <= 1'b0;
                    end
`ifdef INT_ACK_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        // withdraw; pending is kept so the line is re-arbitrated
                        state_q   <= S_IDLE;
                        req_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_SERVICE: begin
                    if (irq_ret) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_id_en = id_en_q;
    assign irq_id_D  = id_q;
    assign irq_req   = req_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
`ifdef INT_ACK_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed handshake scenarios plus randomized transactions against
// a transaction-level pending/priority model; LOAD IDs are checked from a scoreboard queue.
module tb_int_ctrl;

    localparam logic [30:0] ALL = 31'h7fff_ffff;

    logic        clk = 1'b0;
    logic        res;
    logic [30:0] irq_lines, irq_mask;
    logic        gie, irq_ack, irq_ret;
    logic        irq_id_en, irq_req, busy, timeout;
    logic [4:0]  irq_id_D;
    logic [30:0] pending;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_q[$];
    bit          mon_en = 1'b0;

    logic [30:0] model_pend = '0;
    logic [30:0] prev_lines = '0;
    int          model_ack_id = 0;

    int_ctrl #(.NUM_IRQ(31), .ID_W(5), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .res(res), .irq_lines(irq_lines), .irq_mask(irq_mask), .gie(gie),
        .irq_ack(irq_ack), .irq_ret(irq_ret), .irq_id_en(irq_id_en), .irq_id_D(irq_id_D),
        .irq_req(irq_req), .busy(busy), .pending(pending), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every capture-register load must match the oldest expected ID.
    always @(negedge clk) begin
        if (mon_en && !res && irq_id_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL load_id: unexpected load of ID %0d, none expected", irq_id_D);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(irq_id_D) != e) begin
                    n_err++;
                    $display("FAIL load_id: got %0d, expected %0d", irq_id_D, e);
                end
            end
        end
    end

    function automatic int lowest(input logic [30:0] v);
        for (int i = 0; i < 31; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    // Advance one clock; the model applies this cycle's edges and acknowledged clear.
    task automatic step();
        logic [30:0] rise, clr;
        rise = irq_lines & ~prev_lines;
        clr  = '0;
        if (model_ack_id != 0) clr[model_ack_id-1] = 1'b1;
        @(posedge clk);
        if (res) begin
            model_pend = '0;
            prev_lines = '0;
        end else begin
            model_pend = (model_pend & ~clr) | rise;
            prev_lines = irq_lines;
        end
        model_ack_id = 0;
        #1;
    endtask

    task automatic do_ack(input int id);
        irq_ack = 1'b1;
        model_ack_id = id;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic do_ret();
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!irq_req && k < 12) begin
            step();
            k++;
        end
        chk(name, {31'd0, irq_req}, 32'd1);
    endtask

    initial begin
        int exp_id, cnt;
        res = 1'b1; irq_lines = '0; irq_mask = '0; gie = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
        step(); step();

        // junk activity, then a single reset cycle
        res = 1'b0; irq_mask = ALL; gie = 1'b1;
        repeat (6) begin
            irq_lines = 31'($urandom);
            irq_ack   = 1'($urandom);
            irq_ret   = 1'($urandom);
            step();
        end
        res = 1'b1;
        step();
        res = 1'b0; irq_lines = '0; gie = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
        chk("rst_id_en", {31'd0, irq_id_en}, 0);
        chk("rst_id_D", {27'd0, irq_id_D}, 0);
        chk("rst_req", {31'd0, irq_req}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_pending", {1'b0, pending}, 0);
        mon_en = 1'b1;
        step();
        chk("rst_idle_after", {31'd0, busy}, 0);

        // single IRQ on line 5: latency t+1 / t+2 / t+3
        irq_mask = ALL; gie = 1'b1;
        irq_lines[4] = 1'b1;
        exp_q.push_back(5);
        step();
        chk("single_pend_t1", {1'b0, pending}, 32'h10);
        chk("single_en_t1", {31'd0, irq_id_en}, 0);
        step();
        chk("single_en_t2", {31'd0, irq_id_en}, 1);
        chk("single_D_t2", {27'd0, irq_id_D}, 5);
        chk("single_req_t2", {31'd0, irq_req}, 0);
        step();
        chk("single_req_t3", {31'd0, irq_req}, 1);
        chk("single_en_t3", {31'd0, irq_id_en}, 0);
        do_ack(5);
        chk("single_pend_ack", {1'b0, pending}, {1'b0, model_pend});
        chk("single_svc_busy", {31'd0, busy}, 1);
        chk("single_svc_req", {31'd0, irq_req}, 0);
        do_ret();
        chk("single_ret_busy", {31'd0, busy}, 0);

        // priority with masking: lines 3 and 7 together, line 3 masked
        irq_lines = '0; step();
        irq_mask = ALL & ~31'h4;
        irq_lines = 31'h44;
        exp_q.push_back(7);
        step(); step();
        chk("prio_D_7", {27'd0, irq_id_D}, 7);
        step();
        chk("prio_req_7", {31'd0, irq_req}, 1);
        do_ack(7);
        irq_mask = ALL;
        exp_q.push_back(3);
        do_ret();
        step();
        chk("prio_b2b_load", {31'd0, irq_id_en}, 1);
        chk("prio_D_3", {27'd0, irq_id_D}, 3);
        step();
        do_ack(3);
        do_ret();
        chk("prio_pending_clear", {1'b0, pending}, {1'b0, model_pend});

        // new edge on line 5 in the ack cycle keeps it pending
        irq_lines = '0; step();
        irq_lines[4] = 1'b1;
        exp_q.push_back(5);
        step(); step(); step();
        chk("setclr_req", {31'd0, irq_req}, 1);
        irq_lines = '0; step();
        irq_lines[4] = 1'b1;
        do_ack(5);
        chk("setclr_pend", {1'b0, pending}, 32'h10);
        exp_q.push_back(5);
        do_ret();
        step();
        chk("setclr_reload", {31'd0, irq_id_en}, 1);
        step();
        do_ack(5);
        do_ret();

        // stray handshakes and gie gating
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("stray_ack_busy", {31'd0, busy}, 0);
        gie = 1'b0; irq_lines = '0; step();
        irq_lines[0] = 1'b1; step();
        chk("gie_pend", {1'b0, pending}, 32'h1);
        step(); step();
        chk("gie_off_idle", {31'd0, busy}, 0);
        gie = 1'b1;
        exp_q.push_back(1);
        step();
        chk("gie_on_load", {31'd0, irq_id_en}, 1);
        step();
        do_ret();
        chk("stray_ret_req", {31'd0, irq_req}, 1);
        chk("stray_ret_busy", {31'd0, busy}, 1);
        do_ack(1);
        do_ret();
        chk("gie_done_busy", {31'd0, busy}, 0);

        // ack timeout on ID 2
        irq_lines = '0; step();
        irq_lines[1] = 1'b1;
        exp_q.push_back(2);
        step(); step(); step();
        chk("to_req", {31'd0, irq_req}, 1);
        cnt = 0;
`ifdef INT_ACK_TIMEOUT_EN
        while (irq_req && cnt < 10) begin
            cnt++;
            step();
        end
        chk("to_req_cycles", cnt, 4);
        chk("to_pulse", {31'd0, timeout}, 1);
        chk("to_pend_kept", {1'b0, pending}, 32'h2);
        exp_q.push_back(2);
        step();
        chk("to_pulse_once", {31'd0, timeout}, 0);
        chk("to_reload", {31'd0, irq_id_en}, 1);
        step();
`else
        repeat (100) begin
            if (irq_req && !timeout) cnt++;
            step();
        end
        chk("to_req_held", cnt, 100);
`endif
        do_ack(2);
        do_ret();
        irq_lines = '0; gie = 1'b0; step();

        // randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            gie = 1'b0;
            repeat ($urandom_range(1, 4)) begin
                irq_lines = 31'($urandom) & 31'($urandom);
                step();
            end
            irq_mask = ($urandom_range(0, 3) == 0) ? (31'($urandom) & 31'($urandom) & 31'($urandom))
                                                   : 31'($urandom);
            exp_id = lowest(model_pend & irq_mask);
            if (exp_id != 0) begin
                exp_q.push_back(exp_id);
                gie = 1'b1;
                step();
                gie = 1'($urandom);
                irq_mask = 31'($urandom);
                wait_req("rnd_req");
                repeat ($urandom_range(0, 3)) begin
                    irq_lines = 31'($urandom) & 31'($urandom);
                    step();
                end
                irq_lines = 31'($urandom) & 31'($urandom);
                gie = 1'b0;
                do_ack(exp_id);
                repeat ($urandom_range(0, 3)) begin
                    irq_lines = 31'($urandom) & 31'($urandom);
                    step();
                end
                do_ret();
                chk("rnd_pending", {1'b0, pending}, {1'b0, model_pend});
                chk("rnd_idle", {31'd0, busy}, 0);
            end else begin
                gie = 1'b1;
                repeat (3) step();
                chk("rnd_nocand_idle", {31'd0, busy}, 0);
                gie = 1'b0;
            end
        end

        step(); step();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
